// File: rtl/aud_rate_dsp.sv
// Variable-rate audio playback: fetches CH-word frames from SRAM on each DAC LR-clock
// falling edge; normal/fast/slow-hold/slow-linear. Define AUD_RATE_DSP_LOOP_EN for looped playback.
module aud_rate_dsp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int CH     = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_pause,
  input  logic                   i_stop,
  input  logic [1:0]             i_mode,
  input  logic [2:0]             i_speed,
  input  logic                   i_daclrck,
  input  logic [ADDR_W-1:0]      i_start_addr,
  input  logic [ADDR_W-1:0]      i_end_addr,
  input  logic [DATA_W-1:0]      i_sram_data,
  output logic [ADDR_W-1:0]      o_sram_addr,
  output logic [CH*DATA_W-1:0]   o_dac_data,
  output logic                   o_dac_valid,
  output logic [1:0]             o_state,
  output logic                   o_done
);

  localparam int CW = $clog2(CH + 2);
  localparam int PW = DATA_W + 21;
`ifdef AUD_RATE_DSP_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_FETCH = 2'd2, S_PAUSE = 2'd3} state_t;

  state_t                    r_state, w_state_nxt;
  logic                      r_lrc, r_pause_req, r_dac_valid, r_done;
  logic [CW-1:0]             r_cnt;
  logic [ADDR_W-1:0]         r_p, r_start, r_end, r_sram_addr;
  logic [2:0]                r_k;
  logic [3:0]                r_n;
  logic [1:0]                r_mode;
  logic signed [DATA_W-1:0]  r_cap  [CH];
  logic signed [DATA_W-1:0]  r_prev [CH];
  logic [CH*DATA_W-1:0]      r_dac_data, w_frame;
  logic                      w_lrc_fall, w_frame_end, w_launch, w_fetch_go, w_clip_end;
  logic [ADDR_W-1:0]         w_adv, w_p_nxt;
  logic [ADDR_W:0]           w_p_sum;
  logic [ADDR_W+1:0]         w_last_word;
  logic [2:0]                w_k_nxt;

  function automatic logic [12:0] f_recip(input logic [3:0] n);
    case (n)
      4'd1:    f_recip = 13'd4096;
      4'd2:    f_recip = 13'd2048;
      4'd3:    f_recip = 13'd1365;
      4'd4:    f_recip = 13'd1024;
      4'd5:    f_recip = 13'd819;
      4'd6:    f_recip = 13'd683;
      4'd7:    f_recip = 13'd585;
      4'd8:    f_recip = 13'd512;
      default: f_recip = 13'd4096;
    endcase
  endfunction

  // prev + (cur-prev)*k*R[n] >>> 12 in a wide signed datapath, clamped to DATA_W
  function automatic logic [DATA_W-1:0] f_interp(input logic [DATA_W-1:0] prev,
                                                 input logic [DATA_W-1:0] cur,
                                                 input logic [2:0] k, input logic [3:0] n);
    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0]   prod, kk, rr, pe, sum;
    diff = $signed({cur[DATA_W-1], cur}) - $signed({prev[DATA_W-1], prev});
    prod = {{(PW-DATA_W-1){diff[DATA_W]}}, diff};
    kk   = {{(PW-3){1'b0}}, k};
    rr   = {{(PW-13){1'b0}}, f_recip(n)};
    pe   = {{(PW-DATA_W){prev[DATA_W-1]}}, prev};
    prod = prod * kk * rr;
    sum  = (prod >>> 4'd12) + pe;
    if ((sum[PW-1:DATA_W-1] == '0) || (sum[PW-1:DATA_W-1] == '1)) begin
      f_interp = sum[DATA_W-1:0];
    end else if (sum[PW-1]) begin
      f_interp = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      f_interp = {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  assign w_lrc_fall  = r_lrc & ~i_daclrck;
  assign w_frame_end = (r_cnt == CW'(CH + 1));

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: stop beats everything, pause beats resume
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_stop) w_state_nxt = S_WAIT;
        else                    w_state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (i_stop)          w_state_nxt = S_IDLE;
        else if (i_pause)    w_state_nxt = S_PAUSE;
        else if (w_lrc_fall) w_state_nxt = S_FETCH;
        else                 w_state_nxt = S_WAIT;
      end
      S_FETCH: begin
        if (i_stop)                          w_state_nxt = S_IDLE;
        else if (!w_frame_end)               w_state_nxt = S_FETCH;
        else if (w_clip_end && !LOOP_EN)     w_state_nxt = S_IDLE;
        else if (r_pause_req || i_pause)     w_state_nxt = S_PAUSE;
        else                                 w_state_nxt = S_WAIT;
      end
      S_PAUSE: begin
        if (i_stop)                 w_state_nxt = S_IDLE;
        else if (i_start && !i_pause) w_state_nxt = S_WAIT;
        else                        w_state_nxt = S_PAUSE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode: datapath strobes
  always_comb begin
    w_launch   = (r_state == S_IDLE) && (w_state_nxt == S_WAIT);
    w_fetch_go = (r_state == S_WAIT) && (w_state_nxt == S_FETCH);
  end

  // Pointer advance, end-of-clip test and next phase
  always_comb begin
    w_adv = '0;
    case (r_mode)
      2'b00:   w_adv = ADDR_W'(CH);
      2'b01:   w_adv = ADDR_W'(CH) * ADDR_W'(r_n);
      default: begin
        if (r_k == 3'd0) w_adv = ADDR_W'(CH);
        else             w_adv = '0;
      end
    endcase
    w_p_sum     = {1'b0, r_p} + {1'b0, w_adv};
    w_last_word = {1'b0, w_p_sum} + (ADDR_W+2)'(CH - 1);
    w_clip_end  = (w_adv != '0) && (w_last_word > {2'b00, r_end});
    if (w_clip_end) w_p_nxt = r_start;
    else            w_p_nxt = w_p_sum[ADDR_W-1:0];
    if (w_clip_end || !r_mode[1])            w_k_nxt = 3'd0;
    else if ({1'b0, r_k} == (r_n - 4'd1))   w_k_nxt = 3'd0;
    else                                     w_k_nxt = r_k + 3'd1;
  end

  // Frame to present: fetched frame, held prev, or interpolated
  always_comb begin
    w_frame = '0;
    for (int c = 0; c < CH; c++) begin
      if (!r_mode[1] || (r_k == 3'd0)) begin
        w_frame[c*DATA_W +: DATA_W] = r_cap[c];
      end else if (r_mode == 2'b10) begin
        w_frame[c*DATA_W +: DATA_W] = r_prev[c];
      end else begin
        w_frame[c*DATA_W +: DATA_W] = f_interp(r_prev[c], r_cap[c], r_k, r_n);
      end
    end
  end

  // Playback datapath: pointers, fetch sequencing, capture and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lrc       <= 1'b1;
      r_pause_req <= 1'b0;
      r_cnt       <= '0;
      r_p         <= '0;
      r_start     <= '0;
      r_end       <= '0;
      r_k         <= 3'd0;
      r_n         <= 4'd1;
      r_mode      <= 2'b00;
      r_sram_addr <= '0;
      r_dac_data  <= '0;
      r_dac_valid <= 1'b0;
      r_done      <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        r_cap[c]  <= '0;
        r_prev[c] <= '0;
      end
    end else begin
      r_lrc       <= i_daclrck;
      r_dac_valid <= 1'b0;
      r_done      <= 1'b0;
      if (i_stop) begin
        r_pause_req <= 1'b0;
        r_cnt       <= '0;
        r_sram_addr <= r_p;
      end else if (w_launch) begin
        r_p         <= i_start_addr;
        r_start     <= i_start_addr;
        r_end       <= i_end_addr;
        r_k         <= 3'd0;
        r_sram_addr <= i_start_addr;
      end else if (w_fetch_go) begin
        r_cnt       <= '0;
        r_sram_addr <= r_p;
        if (r_k == 3'd0) begin
          r_mode <= i_mode;
          r_n    <= {1'b0, i_speed} + 4'd1;
        end
      end else if (r_state == S_FETCH) begin
        if (i_pause) r_pause_req <= 1'b1;
        r_cnt <= r_cnt + CW'(1'b1);
        if (r_cnt < CW'(CH - 1)) r_sram_addr <= r_p + ADDR_W'(r_cnt) + ADDR_W'(1'b1);
        // SRAM data lags its address by one cycle, so word c lands at count c+1
        for (int c = 0; c < CH; c++) begin
          if (r_cnt == CW'(c + 1)) r_cap[c] <= i_sram_data;
        end
        if (w_frame_end) begin
          r_dac_data  <= w_frame;
          r_dac_valid <= 1'b1;
          r_done      <= w_clip_end;
          r_p         <= w_p_nxt;
          r_sram_addr <= w_p_nxt;
          r_k         <= w_k_nxt;
          r_pause_req <= 1'b0;
          r_cnt       <= '0;
          if (r_mode[1] && (r_k == 3'd0)) begin
            for (int c = 0; c < CH; c++) r_prev[c] <= r_cap[c];
          end
        end
      end
    end
  end

  assign o_sram_addr = r_sram_addr;
  assign o_dac_data  = r_dac_data;
  assign o_dac_valid = r_dac_valid;
  assign o_done      = r_done;
  assign o_state     = r_state;

endmodule
